// File: rtl/g0table_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : g0table_access_scheduler
// Brief    : Shares one G0 search table between hash-chain search walks and
//            rule writes. Optional counters enabled by G0_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module g0table_access_scheduler #(
  parameter int INDEX_BIT_LEN    = 11,
  parameter int PACKET_BIT_LEN   = 104,
  parameter int ENTRY_DATA_WIDTH = 171,
  parameter int MAX_HOPS         = 8,
  parameter int HOP_CNT_W        = 4,
  parameter int NULL_INDEX       = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        srch_valid,
  output logic                        srch_ready,
  input  logic [INDEX_BIT_LEN-1:0]    srch_index,
  input  logic [PACKET_BIT_LEN-1:0]   srch_tuple,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [INDEX_BIT_LEN-1:0]    upd_index,
  input  logic [ENTRY_DATA_WIDTH-1:0] upd_data,
  output logic                        res_valid,
  output logic                        res_hit,
  output logic [INDEX_BIT_LEN-1:0]    res_ruleID,
  output logic [HOP_CNT_W-1:0]        res_hops,
  output logic                        tbl_we,
  output logic [ENTRY_DATA_WIDTH-1:0] tbl_din,
  output logic [INDEX_BIT_LEN-1:0]    tbl_index,
  output logic [PACKET_BIT_LEN-1:0]   tbl_tuple,
  input  logic                        tbl_match,
  input  logic [INDEX_BIT_LEN-1:0]    tbl_ruleID,
  input  logic [INDEX_BIT_LEN-1:0]    tbl_next_index,
  output logic                        busy,
  output logic [31:0]                 stat_search_cnt,
  output logic [31:0]                 stat_hit_cnt,
  output logic [31:0]                 stat_upd_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [INDEX_BIT_LEN-1:0] c_null_idx = INDEX_BIT_LEN'(NULL_INDEX);
  localparam logic [HOP_CNT_W-1:0]     c_max_hops = HOP_CNT_W'(MAX_HOPS);

  state_t               r_state;
  state_t               w_next_state;
  logic [HOP_CNT_W-1:0] r_hops;
  logic                 r_rr_upd;
  logic                 w_srch_fire;
  logic                 w_upd_fire;
  logic                 w_walk_done;
  logic                 w_grant_srch;
  logic                 w_grant_upd;

  assign w_srch_fire = srch_valid & srch_ready;
  assign w_upd_fire  = upd_valid & upd_ready;
  assign w_walk_done = tbl_match | (tbl_next_index == c_null_idx) | (r_hops == c_max_hops);
  assign busy        = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_srch = 1'b0;
    w_grant_upd  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_srch_fire)     w_next_state = ST_ISSUE;
        else if (w_upd_fire) w_next_state = ST_WRITE;
      end
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT:  w_next_state = w_walk_done ? ST_RESP : ST_ISSUE;
      ST_WRITE: w_next_state = ST_IDLE;
      ST_RESP:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
    // Grant decided one cycle ahead so ready leaves a flop; only offered into IDLE.
    if (w_next_state == ST_IDLE) begin
      if (srch_valid && upd_valid) begin
        w_grant_upd  = r_rr_upd;
        w_grant_srch = ~r_rr_upd;
      end else begin
        w_grant_srch = srch_valid;
        w_grant_upd  = upd_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srch_ready <= 1'b0;
      upd_ready  <= 1'b0;
      res_valid  <= 1'b0;
      res_hit    <= 1'b0;
      res_ruleID <= '0;
      res_hops   <= '0;
      tbl_we     <= 1'b0;
      tbl_din    <= '0;
      tbl_index  <= '0;
      tbl_tuple  <= '0;
      r_hops     <= '0;
      r_rr_upd   <= 1'b0;
    end else begin
      srch_ready <= w_grant_srch;
      upd_ready  <= w_grant_upd;
      res_valid  <= 1'b0;
      tbl_we     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_srch_fire) begin
            tbl_index <= srch_index;
            tbl_tuple <= srch_tuple;
            r_hops    <= '0;
            r_rr_upd  <= 1'b1;
          end else if (w_upd_fire) begin
            tbl_index <= upd_index;
            tbl_din   <= upd_data;
            tbl_we    <= 1'b1;
            r_rr_upd  <= 1'b0;
          end
        end
        ST_ISSUE: r_hops <= r_hops + 1'b1;
        ST_WAIT: begin
          if (w_walk_done) begin
            res_valid  <= 1'b1;
            res_hit    <= tbl_match;
            res_ruleID <= tbl_match ? tbl_ruleID : '0;
            res_hops   <= r_hops;
          end else begin
            tbl_index  <= tbl_next_index;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef G0_SCHED_STATS_EN
  logic [31:0] r_search_cnt;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_upd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_search_cnt <= '0;
      r_hit_cnt    <= '0;
      r_upd_cnt    <= '0;
    end else begin
      if (r_state == ST_RESP) begin
        r_search_cnt <= r_search_cnt + 32'd1;
        if (res_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (r_state == ST_WRITE) r_upd_cnt <= r_upd_cnt + 32'd1;
    end
  end

  assign stat_search_cnt = r_search_cnt;
  assign stat_hit_cnt    = r_hit_cnt;
  assign stat_upd_cnt    = r_upd_cnt;
`else
  assign stat_search_cnt = '0;
  assign stat_hit_cnt    = '0;
  assign stat_upd_cnt    = '0;
`endif

endmodule
`default_nettype wire
